// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared op codes, sequencer states and default widths for the PE sequencer
package pe_pkg;

    // Operation selector shared by the sequencer, the PE and the offset generator
    typedef enum logic [1:0] {
        OP_GEMM = 2'b00,
        OP_DIV  = 2'b01,
        OP_EXP  = 2'b10,
        OP_LOG  = 2'b11
    } uno_op_t;

    // Sequencer states: one request walks IDLE -> LOAD -> RUN -> DRAIN -> RESP -> IDLE
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } seq_state_t;

    localparam int MUL_BW_DEF   = 16;
    localparam int ACC_BW_DEF   = 32;
    localparam int LEN_BW_DEF   = 8;
    localparam int PIPE_LAT_DEF = 2;

    localparam int PERF_BW = 32;

endpackage

// File: rtl/pe_uno_perf_cnt.sv
// rtl/pe_uno_perf_cnt.sv - 32-bit saturating event counter for sequencer statistics
module pe_uno_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    // Count one per qualifying cycle and stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pe_uno_seq.sv
// rtl/pe_uno_seq.sv - single-request GEMM/unary op sequencer for one PE (optional PE_UNO_SEQ_PERF_EN counters)
module pe_uno_seq
    import pe_pkg::*;
#(
    parameter int MUL_BW   = MUL_BW_DEF,
    parameter int ACC_BW   = ACC_BW_DEF,
    parameter int LEN_BW   = LEN_BW_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [MUL_BW-1:0] req_x_i,
    input  logic [LEN_BW-1:0] req_len_i,
    output logic [1:0]        pe_op_o,
    output logic [MUL_BW-1:0] pe_x_o,
    output logic              pe_clr_o,
    output logic              pe_en_o,
    output logic [LEN_BW-1:0] pe_idx_o,
    input  logic [ACC_BW-1:0] pe_acc_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [1:0]        resp_op_o,
    output logic [ACC_BW-1:0] resp_data_o,
    output logic              busy_o
`ifdef PE_UNO_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_ops_o,
    output logic [31:0]       perf_busy_o
`endif
);

    localparam logic [LEN_BW-1:0] LEN_ONE    = {{(LEN_BW-1){1'b0}}, 1'b1};
    localparam logic [LEN_BW-1:0] LEN_ZERO   = '0;
    localparam logic [3:0]        DRAIN_INIT = 4'(PIPE_LAT - 1);

    seq_state_t        state;
    logic [LEN_BW-1:0] len_q;
    logic [LEN_BW-1:0] cnt;
    logic [3:0]        dcnt;

    // The iteration counter doubles as the coefficient/bitstream index; it is zero outside RUN
    assign pe_idx_o = cnt;

    // State register decodes straight to busy so it drops together with the async reset
    assign busy_o = (state != IDLE);

    // Sequencer FSM: all PE-facing and handshake outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            len_q        <= LEN_ZERO;
            cnt          <= LEN_ZERO;
            dcnt         <= 4'd0;
            pe_op_o      <= 2'b00;
            pe_x_o       <= '0;
            pe_clr_o     <= 1'b0;
            pe_en_o      <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_op_o    <= 2'b00;
            resp_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        // A zero length still runs one MAC step so the PE always sees an enable
                        len_q       <= (req_len_i == LEN_ZERO) ? LEN_ONE : req_len_i;
                        cnt         <= LEN_ZERO;
                        pe_op_o     <= req_op_i;
                        pe_x_o      <= req_x_i;
                        pe_clr_o    <= 1'b1;
                        req_ready_o <= 1'b0;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    // Clear cycle lets the registered offset generator settle on the new operand
                    pe_clr_o <= 1'b0;
                    pe_en_o  <= 1'b1;
                    state    <= RUN;
                end

                RUN: begin
                    // Compare against len-1 so len = 2^LEN_BW-1 finishes before cnt could wrap
                    if (cnt == (len_q - LEN_ONE)) begin
                        pe_en_o <= 1'b0;
                        cnt     <= LEN_ZERO;
                        dcnt    <= DRAIN_INIT;
                        state   <= DRAIN;
                    end else begin
                        cnt <= cnt + LEN_ONE;
                    end
                end

                DRAIN: begin
                    // Wait for the last MAC step to reach the accumulator, then snapshot it
                    if (dcnt == 4'd0) begin
                        resp_data_o  <= pe_acc_i;
                        resp_op_o    <= pe_op_o;
                        resp_valid_o <= 1'b1;
                        pe_op_o      <= 2'b00;
                        pe_x_o       <= '0;
                        state        <= RESP;
                    end else begin
                        dcnt <= dcnt - 4'd1;
                    end
                end

                RESP: begin
                    // Result is held until the consumer takes it; no new request overlaps it
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b1;
                    pe_clr_o     <= 1'b0;
                    pe_en_o      <= 1'b0;
                    resp_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_UNO_SEQ_PERF_EN
    logic resp_fire;

    // A completed op is counted on its response handshake
    assign resp_fire = (state == RESP) && resp_ready_i;

    pe_uno_perf_cnt u_perf_ops (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resp_fire),
        .count (perf_ops_o)
    );

    pe_uno_perf_cnt u_perf_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (busy_o),
        .count (perf_busy_o)
    );
`endif

endmodule

// File: tb/tb_pe_uno_seq.sv
// tb/tb_pe_uno_seq.sv - directed table-driven bench for pe_uno_seq
module tb_pe_uno_seq;

    localparam int MUL_BW   = 16;
    localparam int ACC_BW   = 32;
    localparam int LEN_BW   = 8;
    localparam int PIPE_LAT = 2;

    logic              clk;
    logic              rst_n;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic [MUL_BW-1:0] req_x_i;
    logic [LEN_BW-1:0] req_len_i;
    logic [1:0]        pe_op_o;
    logic [MUL_BW-1:0] pe_x_o;
    logic              pe_clr_o;
    logic              pe_en_o;
    logic [LEN_BW-1:0] pe_idx_o;
    logic [ACC_BW-1:0] pe_acc_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [1:0]        resp_op_o;
    logic [ACC_BW-1:0] resp_data_o;
    logic              busy_o;
`ifdef PE_UNO_SEQ_PERF_EN
    logic [31:0]       perf_ops_o;
    logic [31:0]       perf_busy_o;
`endif

    pe_uno_seq #(
        .MUL_BW   (MUL_BW),
        .ACC_BW   (ACC_BW),
        .LEN_BW   (LEN_BW),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_x_i      (req_x_i),
        .req_len_i    (req_len_i),
        .pe_op_o      (pe_op_o),
        .pe_x_o       (pe_x_o),
        .pe_clr_o     (pe_clr_o),
        .pe_en_o      (pe_en_o),
        .pe_idx_o     (pe_idx_o),
        .pe_acc_i     (pe_acc_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_op_o    (resp_op_o),
        .resp_data_o  (resp_data_o),
        .busy_o       (busy_o)
`ifdef PE_UNO_SEQ_PERF_EN
        ,
        .perf_ops_o   (perf_ops_o),
        .perf_busy_o  (perf_busy_o)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] x;
        logic [7:0]  len;
        int          wait_cyc;
        int          exp_en;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [ACC_BW-1:0] acc_prev;
    int unsigned acc_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator stand-in changes shortly after every edge; acc_prev is what the last edge saw
    initial begin
        pe_acc_i = 32'hC0DE_0000;
        acc_prev = 32'hC0DE_0000;
        forever begin
            @(posedge clk);
            #2;
            acc_prev = pe_acc_i;
            acc_cyc  = acc_cyc + 1;
            pe_acc_i = 32'hC0DE_0000 + acc_cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int en_cnt, clr_cnt, bad_idx, bad_drv, lat, unstable;
        bit seen;
        logic [ACC_BW-1:0] exp_data, hold_data;
        logic [1:0] hold_op;
        en_cnt = 0; clr_cnt = 0; bad_idx = 0; bad_drv = 0; lat = -1; unstable = 0;
        seen = 1'b0; exp_data = '0;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1; req_op_i = v.op; req_x_i = v.x; req_len_i = v.len;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0; req_op_i = 2'b00; req_x_i = '0; req_len_i = '0;
        for (int k = 0; k < 600; k++) begin
            if (k > 0) @(negedge clk);
            if (resp_valid_o) begin
                seen = 1'b1; lat = k; exp_data = acc_prev;
                break;
            end
            if (pe_clr_o) clr_cnt++;
            if (pe_en_o) begin
                if (pe_idx_o != LEN_BW'(en_cnt)) bad_idx++;
                en_cnt++;
            end
            if (pe_op_o != v.op || pe_x_o != v.x || !busy_o || req_ready_o) bad_drv++;
        end
        chk("resp_seen", {63'd0, seen}, 64'd1);
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("clr_cycles", 64'(clr_cnt), 64'd1);
        chk("en_cycles", 64'(en_cnt), 64'(v.exp_en));
        chk("idx_seq_bad", 64'(bad_idx), 64'd0);
        chk("pe_drive_bad", 64'(bad_drv), 64'd0);
        chk("resp_data", 64'(resp_data_o), 64'(exp_data));
        chk("resp_op", 64'(resp_op_o), 64'(v.op));
        hold_data = exp_data; hold_op = v.op;
        for (int w = 0; w < v.wait_cyc; w++) begin
            resp_ready_i = 1'b0;
            req_valid_i = 1'b1; req_op_i = ~v.op; req_x_i = 16'h1234; req_len_i = 8'd9;
            @(negedge clk);
            if (!resp_valid_o || resp_data_o != hold_data || resp_op_o != hold_op || req_ready_o)
                unstable++;
        end
        req_valid_i = 1'b0;
        chk("resp_hold_bad", 64'(unstable), 64'd0);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("post_resp_idle", {60'd0, resp_valid_o, req_ready_o, busy_o, pe_en_o}, {60'd0, 4'b0100});
        chk("post_resp_pe_zero", {46'd0, pe_op_o, pe_x_o}, 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        // {op, x, len, response wait, expected pe_en cycles, expected handshake-to-valid latency}
        vecs[0] = '{2'b11, 16'h0100, 8'd4,   0,  4,   7};
        vecs[1] = '{2'b00, 16'h8000, 8'd0,   0,  1,   4};
        vecs[2] = '{2'b01, 16'h7FFF, 8'd255, 0,  255, 258};
        vecs[3] = '{2'b10, 16'hFFFF, 8'd3,   10, 3,   6};
        vecs[4] = '{2'b11, 16'h00A5, 8'd1,   2,  1,   4};

        rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 2'b00; req_x_i = '0; req_len_i = '0;
        resp_ready_i = 1'b0;
        #23;
        chk("rst_outputs", {58'd0, req_ready_o, pe_clr_o, pe_en_o, resp_valid_o, busy_o, 1'b0},
            {58'd0, 6'b100000});
        chk("rst_data", {14'd0, resp_data_o, pe_op_o, pe_x_o}, 64'd0);
`ifdef PE_UNO_SEQ_PERF_EN
        chk("rst_perf", {perf_ops_o, perf_busy_o}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Early resp_ready in idle must not disturb the next transaction
        @(negedge clk);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("early_ready_no_resp", {63'd0, resp_valid_o}, 64'd0);

        // Reset during the second RUN cycle
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = 2'b10; req_x_i = 16'h0042; req_len_i = 8'd8;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_run_en", {56'd0, pe_en_o, pe_idx_o[6:0]}, {56'd0, 1'b1, 7'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_async", {59'd0, pe_en_o, pe_clr_o, resp_valid_o, busy_o, req_ready_o},
            {59'd0, 5'b00001});
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (resp_valid_o || !req_ready_o || busy_o || pe_en_o) bad++;
            end
            chk("post_rst_quiet", 64'(bad), 64'd0);
        end

`ifdef PE_UNO_SEQ_PERF_EN
        // Fresh counters, then three len=2 ops with the consumer always ready: 6 busy cycles each
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t pv;
            pv = '{2'b00, 16'h0003, 8'd2, 0, 2, 5};
            for (int j = 0; j < 3; j++) run_txn(pv);
        end
        @(negedge clk);
        chk("perf_ops", 64'(perf_ops_o), 64'd3);
        chk("perf_busy", 64'(perf_busy_o), 64'd18);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so a stuck sequence still ends the run
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
